// File: rtl/byte_word_assembler_pkg.sv
// Shared definitions for the byte-to-word assembler on the pipeline debug path.
// Holds the FSM state encoding and the default byte/word widths.
package byte_word_assembler_pkg;

    // Encodings are fixed so the debug path can decode state from other tools.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StHold    = 2'd2
    } asm_state_e;

    localparam int unsigned DefaultNbByte = 8;
    localparam int unsigned DefaultNbData = 32;

endpackage

// File: rtl/byte_word_assembler_idle_timeout_counter.sv
// Idle-cycle watchdog for a partially assembled word.
// Ports:
//   i_clk      rising-edge clock
//   i_reset    synchronous active-high reset
//   i_enable   count only while a partial word is open
//   i_restart  an accepted byte (or an abort) restarts the idle window
//   o_expire   combinational: this cycle is the last idle cycle allowed
// TIMEOUT_CYCLES = 0 disables the watchdog entirely.
module byte_word_assembler_idle_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_expire
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt =
        (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit Enabled = (TIMEOUT_CYCLES != 0);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        o_expire = Enabled && i_enable && !i_restart && (cnt_q == LastCnt);
    end

    always_comb begin
        cnt_d = cnt_q;
        // Expiry also zeroes the count, so it can never run past LastCnt.
        if (!Enabled || !i_enable || i_restart || o_expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/byte_word_assembler.sv
// Byte-to-word assembler: packs consecutive bytes into the lanes of an NB_DATA-bit
// word and hands it to the consumer through a one-word valid/ready holding register.
// A partial word left idle for TIMEOUT_CYCLES cycles is dropped and flagged.
// Ports:
//   i_clk, i_reset          clock and synchronous active-high reset
//   i_byte, i_byte_valid    incoming byte stream
//   o_byte_ready            byte can be accepted this cycle
//   i_clear                 synchronous abort of partial and held word
//   o_word, o_word_valid    assembled word and its valid
//   i_word_ready            consumer accepts o_word
//   o_byte_count            lanes filled in the current partial word
//   o_timeout_err           one-cycle pulse when a partial word times out
module byte_word_assembler
    import byte_word_assembler_pkg::*;
#(
    parameter int unsigned NB_DATA        = DefaultNbData,
    parameter int unsigned NB_BYTE        = DefaultNbByte,
    parameter bit          BIG_ENDIAN     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int unsigned NB_LANES      = NB_DATA / NB_BYTE,
    localparam int unsigned NB_CNT        = $clog2(NB_LANES) + 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_byte,
    input  logic               i_byte_valid,
    output logic               o_byte_ready,
    input  logic               i_clear,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_word_valid,
    input  logic               i_word_ready,
    output logic [NB_CNT-1:0]  o_byte_count,
    output logic               o_timeout_err
);

    localparam logic [NB_CNT-1:0] LastLane = NB_CNT'(NB_LANES - 1);

    asm_state_e         state_q, state_d;
    logic [NB_CNT-1:0]  count_q, count_d;
    logic [NB_DATA-1:0] partial_q, partial_d;
    logic [NB_DATA-1:0] word_q, word_d;
    logic               word_valid_q, word_valid_d;
    logic               timeout_err_q, timeout_err_d;

    logic               accept;
    logic               expire;
    int unsigned        lane_sel;
    logic [NB_DATA-1:0] merged_word;

    always_comb begin
        o_byte_ready = !i_reset && !i_clear && (state_q != StHold);
        accept       = i_byte_valid && o_byte_ready;
    end

    byte_word_assembler_idle_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (state_q == StCollect),
        .i_restart(accept || i_clear),
        .o_expire (expire)
    );

    // Physical lane for byte k: LS-first for little endian, MS-first for big endian.
    always_comb begin
        if (BIG_ENDIAN) begin
            lane_sel = NB_LANES - 1 - 32'(count_q);
        end else begin
            lane_sel = 32'(count_q);
        end
        merged_word = partial_q;
        for (int unsigned l = 0; l < NB_LANES; l++) begin
            if (l == lane_sel) begin
                merged_word[l*NB_BYTE +: NB_BYTE] = i_byte;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        partial_d     = partial_q;
        word_d        = word_q;
        word_valid_d  = word_valid_q;
        timeout_err_d = 1'b0;

        if (i_clear) begin
            // A same-cycle handshake is simply lost along with everything else.
            state_d      = StIdle;
            count_d      = '0;
            partial_d    = '0;
            word_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (NB_LANES == 1) begin
                            word_d       = merged_word;
                            word_valid_d = 1'b1;
                            partial_d    = '0;
                            count_d      = '0;
                            state_d      = StHold;
                        end else begin
                            partial_d = merged_word;
                            count_d   = NB_CNT'(1);
                            state_d   = StCollect;
                        end
                    end
                end
                StCollect: begin
                    if (accept) begin
                        if (count_q == LastLane) begin
                            word_d       = merged_word;
                            word_valid_d = 1'b1;
                            partial_d    = '0;
                            count_d      = '0;
                            state_d      = StHold;
                        end else begin
                            partial_d = merged_word;
                            count_d   = count_q + NB_CNT'(1);
                        end
                    end else if (expire) begin
                        partial_d     = '0;
                        count_d       = '0;
                        state_d       = StIdle;
                        timeout_err_d = 1'b1;
                    end
                end
                StHold: begin
                    // o_word is kept after the handshake; only valid drops.
                    if (word_valid_q && i_word_ready) begin
                        word_valid_d = 1'b0;
                        state_d      = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= StIdle;
            count_q       <= '0;
            partial_q     <= '0;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            partial_q     <= partial_d;
            word_q        <= word_d;
            word_valid_q  <= word_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        o_word        = word_q;
        o_word_valid  = word_valid_q;
        o_byte_count  = count_q;
        o_timeout_err = timeout_err_q;
    end

endmodule
